hit_locator: RTL and testbench
==============================

# hit_locator

Recovers the on-screen position of a bright marker from the VGA pixel stream: it thresholds every active pixel, accumulates coordinate sums and a hit count over one frame, then divides sequentially to produce the marker centroid. It is the inverse of the hit-marker renderer, which draws a marker at (x, y). The locator is fed the composited or camera pixel stream, and it returns (x, y) to target/scoring logic once per frame.

## Interface
- H_ACTIVE, 1024, active pixels per line; hcount >= H_ACTIVE is blanking.
- V_ACTIVE, 768, active lines per frame; vcount >= V_ACTIVE is blanking.
- THRESH, 8'hC0, per-channel threshold; a pixel is a hit when R, G and B are each >= THRESH.
- MIN_COUNT, 4, minimum hits for a valid detection; must be >= 1.
- clk  in  1  pixel clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hcount  in  11  horizontal position of the current pixel.
- vcount  in  10  vertical position of the current pixel.
- pixel  in  24  {R[23:16], G[15:8], B[7:0]}, aligned with hcount/vcount in the same cycle.
- x  out  11  centroid column; 0 at reset; holds between updates.
- y  out  10  centroid row; 0 at reset; holds between updates.
- found  out  1  1 when the last completed frame had count >= MIN_COUNT; 0 at reset.
- valid  out  1  one-cycle pulse when x/y/found update; 0 at reset.

## Operation
- A sample is active when hcount < H_ACTIVE and vcount < V_ACTIVE. An active sample that passes the threshold adds hcount to sum_x (30 bits), vcount to sum_y (30 bits), and 1 to cnt (20 bits). Inactive samples and below-threshold samples change nothing.
- The frame end is the sample with hcount == H_ACTIVE-1 and vcount == V_ACTIVE-1. On that edge:
  - the final sample's contribution is included;
  - the totals are copied to tot_x, tot_y and tot_n;
  - sum_x, sum_y and cnt are cleared to 0.
- Accumulation never stops. A new frame accumulates while the divider runs on the latched totals.
- FSM, reset state ACC:
  - ACC: wait for the frame end. If the latched tot_n >= MIN_COUNT, go to DIV. Otherwise go to DONE with found_next = 0.
  - DIV: two restoring dividers run in parallel, tot_x/tot_n and tot_y/tot_n. Each processes one quotient bit per cycle, MSB first, with a 30-bit dividend and a 20-bit divisor, for exactly 30 iterations. Then go to DONE with found_next = 1.
  - DONE: for one cycle, assert valid and update the outputs, then go to ACC.
- Output update on found_next = 1: x and y take quotient[10:0] and quotient[9:0]. The quotient is truncated toward zero and is always <= H_ACTIVE-1 or V_ACTIVE-1, so no saturation is needed.
- Output update on found_next = 0: x and y hold their previous values; found = 0.
- A frame end arriving while in DIV or DONE is a protocol violation, because blanking is far longer than 32 cycles. The frame is dropped: the accumulators still clear, but the totals are not re-latched.
- Reset assertion at any time clears the following asynchronously: all accumulators, totals, divider state, x, y, found and valid; the FSM returns to ACC. The partial frame in progress is lost. Accumulation restarts from the first active sample after rst_n deasserts.

## Timing
- Let E0 be the edge sampling the frame-end pixel.
- Path with hits (tot_n >= MIN_COUNT):
  - DIV iterations occupy edges E1..E30.
  - The edge E31 enters DONE, and x, y, found and valid become visible after E31.
  - valid is high for exactly one cycle and deasserts at E32.
  - Latency from the frame-end sample to valid is 31 clocks.
- Path with too few hits: the edge E1 enters DONE, and valid is visible after E1 (latency 1 clock).
- valid never asserts at any other time, and never more than once per frame.
- x, y and found change only on the edge that raises valid.

## Test plan
- Centred block: 5x5 white (24'hFFFFFF) square spanning x 98..102 and y 198..202, all other pixels black -> valid 31 cycles after the frame end, x=100, y=200, found=1.
- Empty frame following the centred-block frame -> valid 1 cycle after the frame end, found=0, x=100 and y=200 held.
- Threshold and blanking:
  - 3 pixels of 24'hFFBFFF plus 10 white pixels at hcount=1030 (blanking) -> count 0, found=0.
  - 4 pixels of 24'hC0C0C0 at (10,5), (11,5), (10,6), (11,6) -> x=10, y=5 (truncation), found=1.
- Boundary: 4 white pixels at (1023,767), (1023,766), (1022,767), (1022,766) -> x=1022, y=766. This confirms the final frame-end sample is counted.
- Reset: pull rst_n low 10 cycles into DIV -> x=0, y=0, found=0, valid=0 immediately. No valid for that frame. The next full frame with the centred block gives x=100, y=200.
- Back-to-back frames with the block moved from (100,200) to (500,300) -> two valid pulses, reporting (100,200) and then (500,300). The second frame's accumulation is unaffected by the overlapping DIV.

Source files
------------

// File: rtl/hit_locator.sv
// Thresholds the active pixel stream, accumulates hit coordinates over a frame,
// then divides the latched totals sequentially to report the marker centroid.
//
// state | meaning
// ACC   | accumulating; waiting for a latched frame to evaluate
// DIV   | 30-step restoring divide of tot_x/tot_n and tot_y/tot_n
// DONE  | one-cycle valid pulse with updated x/y/found
module hit_locator #(
  parameter int          H_ACTIVE  = 1024,
  parameter int          V_ACTIVE  = 768,
  parameter logic [7:0]  THRESH    = 8'hC0,
  parameter int          MIN_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [23:0] pixel,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        found,
  output logic        valid
);

  localparam logic [1:0] ACC  = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [4:0]  DIV_BITS = 5'd30;

  logic [1:0]  state;
  logic [4:0]  iter;
  logic        pending;
  logic [29:0] sum_x, sum_y, tot_x, tot_y;
  logic [19:0] cnt, tot_n;
  logic [29:0] sum_x_next, sum_y_next;
  logic [19:0] cnt_next;
  logic [19:0] rem_x, rem_y;
  logic [29:0] quo_x, quo_y;
  logic [49:0] step_x, step_y;
  logic        active, hit, frame_end;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [49:0] div_step(input logic [19:0] rem,
                                           input logic [29:0] quo,
                                           input logic [19:0] d);
    logic [20:0] r;
    logic [29:0] q;
    r = {rem, quo[29]};
    q = {quo[28:0], 1'b0};
    if (r >= {1'b0, d}) begin
      r    = r - {1'b0, d};
      q[0] = 1'b1;
    end
    return {r[19:0], q};
  endfunction

  always_comb begin
    active     = (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    hit        = active && (pixel[23:16] >= THRESH) && (pixel[15:8] >= THRESH)
                 && (pixel[7:0] >= THRESH);
    frame_end  = (hcount == H_LAST) && (vcount == V_LAST);
    sum_x_next = sum_x + (hit ? {19'd0, hcount} : 30'd0);
    sum_y_next = sum_y + (hit ? {20'd0, vcount} : 30'd0);
    cnt_next   = cnt + {19'd0, hit};
    // First step happens on the ACC->DIV edge, straight from the latched totals.
    step_x     = div_step((state == ACC) ? 20'd0 : rem_x,
                          (state == ACC) ? tot_x : quo_x, tot_n);
    step_y     = div_step((state == ACC) ? 20'd0 : rem_y,
                          (state == ACC) ? tot_y : quo_y, tot_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_x   <= '0;
      sum_y   <= '0;
      cnt     <= '0;
      tot_x   <= '0;
      tot_y   <= '0;
      tot_n   <= '0;
      pending <= 1'b0;
    end else begin
      pending <= 1'b0;
      if (frame_end) begin
        sum_x <= '0;
        sum_y <= '0;
        cnt   <= '0;
        // A frame ending while the divider is busy is dropped.
        if (state == ACC) begin
          tot_x   <= sum_x_next;
          tot_y   <= sum_y_next;
          tot_n   <= cnt_next;
          pending <= 1'b1;
        end
      end else begin
        sum_x <= sum_x_next;
        sum_y <= sum_y_next;
        cnt   <= cnt_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      iter  <= '0;
      rem_x <= '0;
      rem_y <= '0;
      quo_x <= '0;
      quo_y <= '0;
      x     <= '0;
      y     <= '0;
      found <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ACC: begin
          if (pending) begin
            if (tot_n >= 20'(MIN_COUNT)) begin
              state          <= DIV;
              {rem_x, quo_x} <= step_x;
              {rem_y, quo_y} <= step_y;
              iter           <= 5'd1;
            end else begin
              state <= DONE;
              found <= 1'b0;
              valid <= 1'b1;
            end
          end
        end
        DIV: begin
          if (iter == DIV_BITS) begin
            state <= DONE;
            x     <= quo_x[10:0];
            y     <= quo_y[9:0];
            found <= 1'b1;
            valid <= 1'b1;
          end else begin
            {rem_x, quo_x} <= step_x;
            {rem_y, quo_y} <= step_y;
            iter           <= iter + 5'd1;
          end
        end
        DONE:    state <= ACC;
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_locator.sv
// Frame-level bench for hit_locator: table cases, reset/back-to-back sequences,
// and random frames checked against an arithmetic centroid model.
module tb_hit_locator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [23:0] pixel;
  logic [10:0] x;
  logic [9:0]  y;
  logic        found, valid;

  hit_locator dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .pixel(pixel),
    .x(x), .y(y), .found(found), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic [23:0] p;
  } sample_t;

  typedef struct {
    int          bx, by, w, hh;
    logic [23:0] pix;
    int          nblank;
    int          ex, ey, ef, elat;
    string       name;
  } case_t;

  case_t       tbl[7];
  sample_t     fq[$];
  logic [23:0] fe_pix = 24'h0;
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, valid_cnt = 0, v_cyc = 0, vx = 0, vy = 0, vf = 0, stray = 0;
  int mx = 0, my = 0;
  logic [10:0] px = '0;
  logic [9:0]  py = '0;
  logic        pf = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [10:0] h, input logic [9:0] v, input logic [23:0] p);
    hcount = h; vcount = v; pixel = p;
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      valid_cnt++; v_cyc = cyc; vx = int'(x); vy = int'(y); vf = int'(found);
    end
    if (rst_n && !valid && (x !== px || y !== py || found !== pf)) stray++;
    px = x; py = y; pf = found;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) tick(11'd1100, 10'd0, 24'h0);
  endtask

  task automatic add_rect(input int bx, input int by, input int w, input int hh,
                          input logic [23:0] pix);
    for (int r = by; r < by + hh; r++)
      for (int c = bx; c < bx + w; c++)
        if (c == 1023 && r == 767) fe_pix = pix;
        else fq.push_back(sample_t'{11'(c), 10'(r), pix});
  endtask

  function automatic bit is_hit(input int h, input int v, input logic [23:0] p);
    logic [7:0] r, g, b;
    r = p[23:16]; g = p[15:8]; b = p[7:0];
    return (h < 1024) && (v < 768) && (r >= 8'hC0) && (g >= 8'hC0) && (b >= 8'hC0);
  endfunction

  task automatic model(output int ex, output int ey, output int ef, output int elat);
    longint sx = 0, sy = 0, n = 0;
    foreach (fq[i])
      if (is_hit(int'(fq[i].h), int'(fq[i].v), fq[i].p)) begin
        sx += fq[i].h; sy += fq[i].v; n++;
      end
    if (is_hit(1023, 767, fe_pix)) begin sx += 1023; sy += 767; n++; end
    if (n >= 4) begin
      ex = int'(sx / n); ey = int'(sy / n); ef = 1; elat = 31;
    end else begin
      ex = mx; ey = my; ef = 0; elat = 1;
    end
  endtask

  task automatic run_frame(input string nm, input int ex, input int ey,
                           input int ef, input int elat);
    int p0, e0;
    p0 = valid_cnt;
    foreach (fq[i]) tick(fq[i].h, fq[i].v, fq[i].p);
    tick(11'd1023, 10'd767, fe_pix);
    e0 = cyc;
    blank(45);
    chk({nm, " pulses"}, valid_cnt - p0, 1);
    chk({nm, " latency"}, v_cyc - e0, elat);
    chk({nm, " x"}, vx, ex);
    chk({nm, " y"}, vy, ey);
    chk({nm, " found"}, vf, ef);
    mx = ex; my = ey;
    fq.delete();
    fe_pix = 24'h0;
  endtask

  initial begin
    int p0, e0, ex, ey, ef, el, n;
    tbl[0] = '{98, 198, 5, 5, 24'hFFFFFF, 0, 100, 200, 1, 31, "centred block"};
    tbl[1] = '{0, 0, 0, 0, 24'hFFFFFF, 0, 100, 200, 0, 1, "empty frame"};
    tbl[2] = '{50, 50, 3, 1, 24'hFFBFFF, 10, 100, 200, 0, 1, "thresh and blanking"};
    tbl[3] = '{10, 5, 2, 2, 24'hC0C0C0, 0, 10, 5, 1, 31, "at threshold"};
    tbl[4] = '{300, 400, 3, 1, 24'hFFFFFF, 0, 10, 5, 0, 1, "three hits"};
    tbl[5] = '{0, 0, 2, 2, 24'hFFFFFF, 0, 0, 0, 1, 31, "min count origin"};
    tbl[6] = '{1022, 766, 2, 2, 24'hFFFFFF, 0, 1022, 766, 1, 31, "bottom-right"};

    rst_n = 1'b0;
    blank(3);
    chk("reset x", int'(x), 0);
    chk("reset y", int'(y), 0);
    chk("reset found", int'(found), 0);
    chk("reset valid", int'(valid), 0);
    rst_n = 1'b1;
    blank(2);

    for (int i = 0; i < 7; i++) begin
      add_rect(tbl[i].bx, tbl[i].by, tbl[i].w, tbl[i].hh, tbl[i].pix);
      for (int j = 0; j < tbl[i].nblank; j++) begin
        fq.push_back(sample_t'{11'd1030, 10'(j), 24'hFFFFFF});
        fq.push_back(sample_t'{11'(j * 3), 10'd770, 24'hFFFFFF});
      end
      run_frame(tbl[i].name, tbl[i].ex, tbl[i].ey, tbl[i].ef, tbl[i].elat);
    end

    // Reset 10 cycles into the divide.
    add_rect(98, 198, 5, 5, 24'hFFFFFF);
    foreach (fq[i]) tick(fq[i].h, fq[i].v, fq[i].p);
    tick(11'd1023, 10'd767, 24'h0);
    blank(10);
    rst_n = 1'b0;
    #1;
    chk("mid-div reset x", int'(x), 0);
    chk("mid-div reset y", int'(y), 0);
    chk("mid-div reset found", int'(found), 0);
    chk("mid-div reset valid", int'(valid), 0);
    p0 = valid_cnt;
    blank(3);
    rst_n = 1'b1;
    blank(40);
    chk("mid-div reset no valid", valid_cnt - p0, 0);
    fq.delete();
    mx = 0; my = 0;
    add_rect(98, 198, 5, 5, 24'hFFFFFF);
    run_frame("after reset", 100, 200, 1, 31);

    // Back-to-back: frame B accumulates while frame A divides.
    add_rect(98, 198, 5, 5, 24'hFFFFFF);
    p0 = valid_cnt;
    foreach (fq[i]) tick(fq[i].h, fq[i].v, fq[i].p);
    tick(11'd1023, 10'd767, 24'h0);
    e0 = cyc;
    fq.delete();
    add_rect(498, 298, 5, 5, 24'hFFFFFF);
    foreach (fq[i]) tick(fq[i].h, fq[i].v, fq[i].p);
    fq.delete();
    blank(45 - (cyc - e0));
    chk("b2b A pulses", valid_cnt - p0, 1);
    chk("b2b A latency", v_cyc - e0, 31);
    chk("b2b A x", vx, 100);
    chk("b2b A y", vy, 200);
    mx = 100; my = 200;
    run_frame("b2b B", 500, 300, 1, 31);

    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, 60);
      for (int i = 0; i < n; i++) begin
        int h, v;
        logic [23:0] p;
        h = $urandom_range(0, 1100);
        v = $urandom_range(0, 800);
        if (h == 1023 && v == 767) h = 0;
        for (int c = 0; c < 3; c++) begin
          case ($urandom_range(0, 3))
            0:       p = {p[15:0], 8'hBF};
            1:       p = {p[15:0], 8'hC0};
            2:       p = {p[15:0], 8'hFF};
            default: p = {p[15:0], 8'($urandom)};
          endcase
        end
        fq.push_back(sample_t'{11'(h), 10'(v), p});
      end
      fe_pix = ($urandom_range(0, 1) == 1) ? 24'hFFFFFF : 24'($urandom);
      model(ex, ey, ef, el);
      run_frame($sformatf("random %0d", k), ex, ey, ef, el);
    end

    chk("outputs changed without valid", stray, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
